unpopcount_int8: RTL and testbench

Bit-serial inverse of the int8 popcount: accepts a 4-bit population count N and builds an 8-bit thermometer word containing exactly N set bits, one bit per cycle, before presenting it on a valid/ready output. It pairs with the popcount benchmarks as the generator side for round-trip checks (popcount(unpopcount(N)) == N). It also serves as a small sequential PIM synthesis benchmark: counter, shift register and FSM.

---
 rtl/unpopcount_pkg.sv | 31 +++
 rtl/unpopcount_int8_if.sv | 30 +++
 rtl/unpopcount_int8_counter.sv | 35 +++
 rtl/unpopcount_int8.sv | 112 +++++++++++
 tb/tb_unpopcount_int8.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/unpopcount_pkg.sv
// ============================================================================
// unpopcount_pkg : shared types, default sizes and count clamping for the
//                  unpopcount generator. Honours UNPOPCOUNT_SATURATE_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package unpopcount_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Out-of-range requests saturate to a full word, or collapse to zero when
  // they are reported through the error flag instead.
  function automatic int unsigned clamp_count(input int unsigned n, input int unsigned width);
`ifdef UNPOPCOUNT_SATURATE_EN
    return (n > width) ? width : n;
`else
    return (n > width) ? 32'd0 : n;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/unpopcount_int8_if.sv
// ============================================================================
// unpopcount_int8_if : count-in / word-out valid-ready bundle.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface unpopcount_int8_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_err;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_word, out_err
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_word, out_err
  );
endinterface

`default_nettype wire

// File: rtl/unpopcount_int8_counter.sv
// ============================================================================
// counter_nbit_down : loadable down-counter that stops at zero, with a zero
//                     flag. Load has priority over decrement.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_nbit_down #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_load_val,
  input  wire logic         i_dec,
  output logic              o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/unpopcount_int8.sv
// ============================================================================
// unpopcount_int8 : bit-serial thermometer generator producing a WIDTH-bit word
//                   with N set bits. Config macro: UNPOPCOUNT_SATURATE_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module unpopcount_int8
  import unpopcount_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int FILL_MSB = 0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  unpopcount_int8_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bitcnt;
  logic             r_err;

  logic             w_accept;
  logic             w_building;
  logic             w_zero;
  logic             w_bit_in;
  logic             w_err_in;
  logic [CNT_W-1:0] w_load_val;
  logic [WIDTH-1:0] w_shreg_nxt;

  assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
  assign w_building = (r_state == ST_BUILD);
  assign w_load_val = CNT_W'(clamp_count({{(32-CNT_W){1'b0}}, bus.in_count},
                                         32'(WIDTH)));
`ifdef UNPOPCOUNT_SATURATE_EN
  assign w_err_in   = 1'b0;
`else
  assign w_err_in   = (bus.in_count > C_WIDTH);
`endif

  counter_nbit_down #(
    .W (CNT_W)
  ) u_remaining (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (w_building),
    .o_zero     (w_zero)
  );

  assign w_bit_in = !w_zero;

  // Both directions leave the first inserted bit at the fill end after WIDTH shifts.
  generate
    if (FILL_MSB != 0) begin : g_fill_msb
      assign w_shreg_nxt = {r_shreg[WIDTH-2:0], w_bit_in};
    end else begin : g_fill_lsb
      assign w_shreg_nxt = {w_bit_in, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_err    <= w_err_in;
            r_state  <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          r_shreg  <= w_shreg_nxt;
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == C_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_word  = r_shreg;
`ifdef UNPOPCOUNT_SATURATE_EN
  assign bus.out_err   = 1'b0;
`else
  assign bus.out_err   = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_unpopcount_int8.sv
// ============================================================================
// tb_unpopcount_int8 : directed self-checking bench for unpopcount_int8, with
//                      one LSB-fill and one MSB-fill instance.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unpopcount_int8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  unpopcount_int8_if #(.WIDTH(8), .CNT_W(4)) b1 ();
  unpopcount_int8_if #(.WIDTH(8), .CNT_W(4)) b2 ();

  unpopcount_int8 #(.WIDTH(8), .CNT_W(4), .FILL_MSB(0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  unpopcount_int8 #(.WIDTH(8), .CNT_W(4), .FILL_MSB(1)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.in_valid = 1'b0; b1.in_count = '0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_count = '0; b2.out_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.out_word !== 8'h00 || b1.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b word=%h err=%b, expected 1 0 00 0",
               b1.in_ready, b1.out_valid, b1.out_word, b1.out_err);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: rdy=%b vld=%b, expected 1 0", b1.in_ready, b1.out_valid);
    end
  endtask

  task automatic test_basic();
    b1.in_valid = 1'b1; b1.in_count = 4'd3; b1.out_ready = 1'b1;
    tick();
    b1.in_valid = 1'b0; b1.in_count = 4'd9;
    n_checks++;
    if (b1.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept_ready: in_ready=%b, expected 0", b1.in_ready);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (b1.out_valid !== (i == 8)) begin
        n_fail++;
        $display("FAIL basic_latency at +%0d: out_valid=%b, expected %b", i, b1.out_valid, (i == 8));
      end
    end
    n_checks++;
    if (b1.out_word !== 8'h07 || b1.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_word: word=%h err=%b, expected 07 0", b1.out_word, b1.out_err);
    end
    tick();
    n_checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return: rdy=%b vld=%b, expected 1 0", b1.in_ready, b1.out_valid);
    end
  endtask

  task automatic test_fill_msb();
    b2.in_valid = 1'b1; b2.in_count = 4'd5; b2.out_ready = 1'b1;
    tick();
    b2.in_valid = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (b2.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_early_valid: out_valid=%b, expected 0", b2.out_valid);
    end
    tick();
    n_checks++;
    if (b2.out_valid !== 1'b1 || b2.out_word !== 8'hF8) begin
      n_fail++;
      $display("FAIL msb_word: vld=%b word=%h, expected 1 f8", b2.out_valid, b2.out_word);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tab [0:8];
    exp_tab = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    b1.out_ready = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      b1.in_valid = 1'b1; b1.in_count = 4'(n);
      tick();
      b1.in_valid = 1'b0;
      n_checks++;
      if (b1.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_accept N=%0d: in_ready=%b, expected 0", n, b1.in_ready);
      end
      repeat (8) tick();
      n_checks++;
      if (b1.out_valid !== 1'b1 || b1.out_word !== exp_tab[n] || $countones(b1.out_word) != n) begin
        n_fail++;
        $display("FAIL sweep_word N=%0d: vld=%b word=%h, expected 1 %h", n, b1.out_valid, b1.out_word, exp_tab[n]);
      end
      tick();
      n_checks++;
      if (b1.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_ready N=%0d: in_ready=%b, expected 1", n, b1.in_ready);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_word;
    logic       exp_err;
`ifdef UNPOPCOUNT_SATURATE_EN
    exp_word = 8'hFF; exp_err = 1'b0;
`else
    exp_word = 8'h00; exp_err = 1'b1;
`endif
    b1.in_valid = 1'b1; b1.in_count = 4'd12; b1.out_ready = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (b1.out_valid !== 1'b1 || b1.out_word !== exp_word || b1.out_err !== exp_err) begin
      n_fail++;
      $display("FAIL overflow_N12: vld=%b word=%h err=%b, expected 1 %h %b",
               b1.out_valid, b1.out_word, b1.out_err, exp_word, exp_err);
    end
    tick();
    // A legal count afterwards must clear the error flag.
    b1.in_valid = 1'b1; b1.in_count = 4'd8;
    tick();
    b1.in_valid = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (b1.out_word !== 8'hFF || b1.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: word=%h err=%b, expected ff 0", b1.out_word, b1.out_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    b1.in_valid = 1'b1; b1.in_count = 4'd6; b1.out_ready = 1'b0;
    tick();
    b1.in_valid = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 20; i++) begin
      b1.in_valid = i[0]; b1.in_count = 4'(i);
      tick();
      n_checks++;
      if (b1.out_valid !== 1'b1 || b1.out_word !== 8'h3F || b1.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc %0d: vld=%b word=%h rdy=%b, expected 1 3f 0",
                 i, b1.out_valid, b1.out_word, b1.in_ready);
      end
    end
    b1.out_ready = 1'b1; b1.in_valid = 1'b1; b1.in_count = 4'd1;
    tick();
    n_checks++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: vld=%b rdy=%b, expected 0 1", b1.out_valid, b1.in_ready);
    end
    tick();
    b1.in_valid = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (b1.out_valid !== 1'b1 || b1.out_word !== 8'h01) begin
      n_fail++;
      $display("FAIL backpressure_next: vld=%b word=%h, expected 1 01", b1.out_valid, b1.out_word);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic seen_valid;
    b1.in_valid = 1'b1; b1.in_count = 4'd7; b1.out_ready = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.out_word !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_async: rdy=%b vld=%b word=%h, expected 1 0 00",
               b1.in_ready, b1.out_valid, b1.out_word);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (10) begin
      tick();
      if (b1.out_valid === 1'b1) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_valid: out_valid seen=%b, expected 0", seen_valid);
    end
    b1.in_valid = 1'b1; b1.in_count = 4'd2;
    tick();
    b1.in_valid = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (b1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_early: out_valid=%b, expected 0", b1.out_valid);
    end
    tick();
    n_checks++;
    if (b1.out_valid !== 1'b1 || b1.out_word !== 8'h03) begin
      n_fail++;
      $display("FAIL abort_next_word: vld=%b word=%h, expected 1 03", b1.out_valid, b1.out_word);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_fill_msb();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
